// File: rtl/tron_pkg.sv
// Shared light-cycle definitions: game-state encodings, trail cell codes,
// grid geometry and the checker FSM state type.
package tron_pkg;

    localparam logic [2:0] GS_TITLE = 3'b000;
    localparam logic [2:0] GS_READY = 3'b001;
    localparam logic [2:0] GS_PLAY  = 3'b010;
    localparam logic [2:0] GS_OVER  = 3'b011;

    localparam logic [2:0] CELL_EMPTY   = 3'd0;
    localparam logic [2:0] CELL_B_HORIZ = 3'd1;
    localparam logic [2:0] CELL_B_VERT  = 3'd2;
    localparam logic [2:0] CELL_R_HORIZ = 3'd3;
    localparam logic [2:0] CELL_R_VERT  = 3'd4;
    localparam logic [2:0] CELL_CORNER  = 3'd5;

    localparam int GRID_W = 112;
    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_B,
        ST_CHK_B,
        ST_RD_R,
        ST_CHK_R,
        ST_DONE
    } chk_state_t;

    // Row-major cell address; callers truncate to their RAM address width.
    function automatic logic [31:0] grid_addr(input logic [7:0] x, input logic [7:0] y,
                                              input int gw);
        return 32'(y) * 32'(gw) + 32'(x);
    endfunction

endpackage

// File: rtl/trail_collision.sv
// Per-frame crash detector: reads both head cells from the trail occupancy RAM
// and raises sticky crash flags for off-grid, head-on or occupied-cell hits.
module trail_collision
    import tron_pkg::*;
#(
    parameter int         GRID_W     = tron_pkg::GRID_W,
    parameter int         ADDR_W     = tron_pkg::ADDR_W,
    parameter logic [2:0] PLAY_STATE = GS_PLAY
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic [2:0]        Game_State,
    input  logic [7:0]        Blue_X,
    input  logic [7:0]        Blue_Y,
    input  logic [7:0]        Red_X,
    input  logic [7:0]        Red_Y,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic              blue_crash,
    output logic              red_crash,
    output logic              check_done,
    output chk_state_t        fsm_state
);

    chk_state_t state;
    logic       frame_prev;
    logic [7:0] bx, by, rx, ry;
    logic [7:0] last_bx, last_by, last_rx, last_ry;
    logic       last_valid;
    logic       blue_pend, red_pend;
    logic       blue_rd, red_rd;

    function automatic logic in_grid(input logic [7:0] x, input logic [7:0] y);
        return (32'(x) < 32'(GRID_W)) && (32'(y) < 32'(GRID_W));
    endfunction

    logic play, tick;
    logic blue_in_now, red_in_now, head_on_now, blue_moved_now;
    logic red_in_lat, red_moved_lat;

    assign play           = (Game_State == PLAY_STATE);
    assign tick           = frame_clk && !frame_prev && play && (state == ST_IDLE)
                            && !blue_crash && !red_crash;
    assign blue_in_now    = in_grid(Blue_X, Blue_Y);
    assign red_in_now     = in_grid(Red_X, Red_Y);
    assign head_on_now    = ({Blue_X, Blue_Y} == {Red_X, Red_Y});
    assign blue_moved_now = !last_valid || ({Blue_X, Blue_Y} != {last_bx, last_by});
    assign red_in_lat     = in_grid(rx, ry);
    assign red_moved_lat  = !last_valid || ({rx, ry} != {last_rx, last_ry});
    assign fsm_state      = state;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            frame_prev <= 1'b0;
            {bx, by, rx, ry} <= '0;
            {last_bx, last_by, last_rx, last_ry} <= '0;
            last_valid <= 1'b0;
            blue_pend  <= 1'b0;
            red_pend   <= 1'b0;
            blue_rd    <= 1'b0;
            red_rd     <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            blue_crash <= 1'b0;
            red_crash  <= 1'b0;
            check_done <= 1'b0;
        end else begin
            frame_prev <= frame_clk;
            check_done <= 1'b0;
            if (!play) begin
                // Leaving play abandons any check and forgets all crash history.
                state      <= ST_IDLE;
                rd_en      <= 1'b0;
                rd_addr    <= '0;
                blue_crash <= 1'b0;
                red_crash  <= 1'b0;
                blue_pend  <= 1'b0;
                red_pend   <= 1'b0;
                blue_rd    <= 1'b0;
                red_rd     <= 1'b0;
                last_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tick) begin
                            {bx, by, rx, ry} <= {Blue_X, Blue_Y, Red_X, Red_Y};
                            blue_pend <= !blue_in_now || head_on_now;
                            red_pend  <= !red_in_now || head_on_now;
                            blue_rd   <= blue_in_now && blue_moved_now;
                            rd_en     <= blue_in_now && blue_moved_now;
                            rd_addr   <= (blue_in_now && blue_moved_now)
                                         ? ADDR_W'(grid_addr(Blue_X, Blue_Y, GRID_W)) : '0;
                            state     <= ST_RD_B;
                        end
                    end
                    ST_RD_B: begin
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        state   <= ST_CHK_B;
                    end
                    ST_CHK_B: begin
                        if (blue_rd && rd_data != CELL_EMPTY) blue_pend <= 1'b1;
                        red_rd  <= red_in_lat && red_moved_lat;
                        rd_en   <= red_in_lat && red_moved_lat;
                        rd_addr <= (red_in_lat && red_moved_lat)
                                   ? ADDR_W'(grid_addr(rx, ry, GRID_W)) : '0;
                        state   <= ST_RD_R;
                    end
                    ST_RD_R: begin
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        state   <= ST_CHK_R;
                    end
                    ST_CHK_R: begin
                        if (red_rd && rd_data != CELL_EMPTY) red_pend <= 1'b1;
                        state <= ST_DONE;
                    end
                    ST_DONE: begin
                        blue_crash <= blue_crash | blue_pend;
                        red_crash  <= red_crash | red_pend;
                        check_done <= 1'b1;
                        {last_bx, last_by, last_rx, last_ry} <= {bx, by, rx, ry};
                        last_valid <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
